key_input_conditioner: RTL

- Board-input front end that sits directly upstream of the mini CPU: it takes the raw active-low push-buttons and the slide switches.
- Each button is synchronised and debounced, and a clean press produces a single-cycle pulse.
- On every confirmed Send press, a stable copy of the switch word is captured, so the CPU sees one instruction per press and never a bouncing or metastable value.

---
 rtl/key_cond_pkg.sv | 23 ++
 rtl/key_debounce.sv | 93 +++++++++
 rtl/key_input_conditioner.sv | 97 +++++++++
 3 files changed

// File: rtl/key_cond_pkg.sv
// rtl/key_cond_pkg.sv - shared types and constants for the key input conditioner
package key_cond_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } deb_state_e;

    localparam int CLK_HZ                = 50_000_000;
    localparam int DEBOUNCE_CYCLES_DEF   = CLK_HZ / 50;
    localparam int LONG_PRESS_CYCLES_DEF = CLK_HZ * 2;

    localparam int KEY_POWER = 0;
    localparam int KEY_SEND  = 1;

    // Counter width able to hold the terminal count itself
    function automatic int cnt_width(input int terminal);
        return $clog2(terminal + 1);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - one key: 2-flop synchroniser, debounce FSM, level and press pulse
module key_debounce
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n_i,
    output logic level_o,
    output logic press_o,
    output logic fire_o,
    output logic held_o
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [1:0]    sync_q;
    deb_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;
    logic          press_q;
    logic          key_low;

    assign key_low = ~sync_q[1];

    // Combinational strobe for the edge on which press_o will rise, so the
    // top can capture data in the same cycle the pulse becomes visible.
    assign fire_o  = (state_q == PRESS_PEND) && key_low && (cnt_q == CNT_MAX);
    assign held_o  = (state_q == PRESSED);
    assign level_o = level_q;
    assign press_o = press_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            state_q <= RELEASED;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], key_n_i};
            press_q <= 1'b0;
            case (state_q)
                RELEASED: begin
                    if (key_low) begin
                        state_q <= PRESS_PEND;
                        cnt_q   <= CNT_ONE;
                    end
                end
                PRESS_PEND: begin
                    if (!key_low) begin
                        state_q <= RELEASED;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!key_low) begin
                        state_q <= RELEASE_PEND;
                        cnt_q   <= CNT_ONE;
                    end
                end
                RELEASE_PEND: begin
                    if (key_low) begin
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q <= RELEASED;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= RELEASED;
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_input_conditioner.sv
// rtl/key_input_conditioner.sv - debounced keys and switch snapshot; LONG_PRESS_EN adds power_long
module key_input_conditioner
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEF,
    parameter int SW_WIDTH          = 18
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          key_n,
    input  logic [SW_WIDTH-1:0] sw,
    output logic                power_level,
    output logic                power_press,
    output logic                power_long,
    output logic                send_press,
    output logic [SW_WIDTH-1:0] sw_snapshot
);

    logic [1:0] level;
    logic [1:0] press;
    logic [1:0] fire;
    logic [1:0] held;

    for (genvar i = 0; i < 2; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_key_debounce (
            .clk     (clk),
            .rst_n   (rst_n),
            .key_n_i (key_n[i]),
            .level_o (level[i]),
            .press_o (press[i]),
            .fire_o  (fire[i]),
            .held_o  (held[i])
        );
    end

    logic unused_key_bits;
    assign unused_key_bits = &{1'b0, level[KEY_SEND], fire[KEY_POWER], held};

    logic [SW_WIDTH-1:0] sw_sync1_q;
    logic [SW_WIDTH-1:0] sw_sync2_q;
    logic [SW_WIDTH-1:0] snap_q;

    // Snapshot loads on the same edge send_press rises
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sw_sync1_q <= '0;
            sw_sync2_q <= '0;
            snap_q     <= '0;
        end else begin
            sw_sync1_q <= sw;
            sw_sync2_q <= sw_sync1_q;
            if (fire[KEY_SEND]) begin
                snap_q <= sw_sync2_q;
            end
        end
    end

`ifdef LONG_PRESS_EN
    localparam int LW = cnt_width(LONG_PRESS_CYCLES);
    localparam logic [LW-1:0] HOLD_MAX = LW'(LONG_PRESS_CYCLES);
    localparam logic [LW-1:0] HOLD_ONE = LW'(1);

    logic [LW-1:0] hold_q;
    logic          long_q;

    // Saturates at the terminal count so a held key fires only once
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            long_q <= 1'b0;
            if (!held[KEY_POWER]) begin
                hold_q <= '0;
            end else if (hold_q != HOLD_MAX) begin
                hold_q <= hold_q + HOLD_ONE;
                if (hold_q == HOLD_MAX - HOLD_ONE) begin
                    long_q <= 1'b1;
                end
            end
        end
    end

    assign power_long = long_q;
`else
    assign power_long = 1'b0;
`endif

    assign power_level = level[KEY_POWER];
    assign power_press = press[KEY_POWER];
    assign send_press  = press[KEY_SEND];
    assign sw_snapshot = snap_q;

endmodule
